// File: rtl/wb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module   : wb_dma_copy
// Function : Chunked word copy engine with a Wishbone pipelined config
//            responder and a Wishbone pipelined bus initiator.
// Revision : 1.0
// ============================================================================
module wb_dma_copy #(
    parameter int WB_AW     = 32,
    parameter int WB_DW     = 32,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               s_cyc_i,
    input  logic               s_stb_i,
    input  logic               s_we_i,
    input  logic [1:0]         s_addr_i,
    input  logic [WB_DW-1:0]   s_wdata_i,
    input  logic [WB_DW/8-1:0] s_sel_i,
    output logic               s_stall_o,
    output logic               s_ack_o,
    output logic               s_err_o,
    output logic [WB_DW-1:0]   s_rdata_o,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    output logic               m_we_o,
    output logic [WB_AW-1:0]   m_addr_o,
    output logic [WB_DW-1:0]   m_wdata_o,
    output logic [WB_DW/8-1:0] m_sel_o,
    input  logic               m_stall_i,
    input  logic               m_ack_i,
    input  logic               m_err_i,
    input  logic [WB_DW-1:0]   m_rdata_i,
    output logic               irq_o
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam int PW = $clog2(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RD2WR = 3'd2,
        S_WR    = 3'd3,
        S_WR2RD = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WB_AW-1:0]   r_src;
    logic [WB_AW-1:0]   r_dst;
    logic [LEN_W-1:0]   r_len;
    logic               r_done;
    logic               r_err;
    logic               r_irq_en;

    logic [WB_AW-1:0]   r_cur_src;
    logic [WB_AW-1:0]   r_cur_dst;
    logic [LEN_W-1:0]   r_remaining;

    logic [CW-1:0]      r_issued;
    logic [CW-1:0]      r_acked;
    logic [CW-1:0]      r_outstanding;

    logic [WB_DW-1:0]   r_mem [MAX_BURST];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;

    logic               r_s_ack;
    logic [WB_DW-1:0]   r_s_rdata;

    logic               w_cfg_req;
    logic               w_cfg_wr;
    logic               w_busy;
    logic               w_start;
    logic [CW-1:0]      w_chunk;
    logic               w_active;
    logic               w_accept;
    logic               w_ack;
    logic               w_abort;
    logic               w_last_ack;
    logic               w_chunk_end;
    logic               w_final;
    logic [WB_DW-1:0]   w_rd_val;
    logic               w_unused;

    assign w_unused    = ^s_sel_i;

    assign w_cfg_req   = s_cyc_i & s_stb_i;
    assign w_cfg_wr    = w_cfg_req & s_we_i;
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = w_cfg_wr && (s_addr_i == 2'd3) && s_wdata_i[0] && !w_busy;
    assign w_chunk     = (r_remaining >= LEN_W'(MAX_BURST)) ? CW'(MAX_BURST) : CW'(r_remaining);
    assign w_active    = (r_state == S_RD) || (r_state == S_WR);

    assign m_cyc_o     = w_active;
    assign m_stb_o     = w_active && (r_issued < w_chunk);
    assign m_we_o      = (r_state == S_WR);
    assign m_sel_o     = '1;
    assign m_addr_o    = !w_active ? '0 :
                         ((r_state == S_WR) ? r_cur_dst : r_cur_src) + WB_AW'(r_issued);
    assign m_wdata_o   = (r_state == S_WR) ? r_mem[r_rd_ptr] : '0;

    // Acks with nothing outstanding (e.g. stragglers after an abort) are dropped.
    assign w_accept    = m_stb_o & ~m_stall_i;
    assign w_ack       = m_ack_i & w_active & (r_outstanding != '0);
    assign w_abort     = m_err_i & w_active;
    assign w_last_ack  = w_ack && ((r_acked + CW'(1)) == w_chunk);
    assign w_chunk_end = (r_state == S_WR) && w_last_ack && !w_abort;
    assign w_final     = (r_remaining == LEN_W'(w_chunk));

    assign s_stall_o   = 1'b0;
    assign s_err_o     = 1'b0;
    assign s_ack_o     = r_s_ack;
    assign s_rdata_o   = r_s_rdata;
    assign irq_o       = r_irq_en & (r_done | r_err);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The gap states keep m_cyc_o low for one cycle between read and write phases.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start && (r_len != '0)) w_next_state = S_RD;
            S_RD: begin
                if (w_abort)         w_next_state = S_IDLE;
                else if (w_last_ack) w_next_state = S_RD2WR;
            end
            S_RD2WR: w_next_state = S_WR;
            S_WR: begin
                if (w_abort)          w_next_state = S_IDLE;
                else if (w_last_ack)  w_next_state = w_final ? S_IDLE : S_WR2RD;
            end
            S_WR2RD: w_next_state = S_RD;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_val = '0;
        case (s_addr_i)
            2'd0:    w_rd_val = WB_DW'(r_src);
            2'd1:    w_rd_val = WB_DW'(r_dst);
            2'd2:    w_rd_val = WB_DW'(r_len);
            default: w_rd_val = WB_DW'({r_irq_en, r_err, r_done, w_busy, 1'b0});
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_irq_en      <= 1'b0;
            r_cur_src     <= '0;
            r_cur_dst     <= '0;
            r_remaining   <= '0;
            r_issued      <= '0;
            r_acked       <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_s_ack       <= 1'b0;
            r_s_rdata     <= '0;
        end else begin
            r_s_ack   <= w_cfg_req;
            r_s_rdata <= (w_cfg_req && !s_we_i) ? w_rd_val : '0;

            if (w_cfg_wr && !w_busy) begin
                case (s_addr_i)
                    2'd0:    r_src <= WB_AW'(s_wdata_i);
                    2'd1:    r_dst <= WB_AW'(s_wdata_i);
                    2'd2:    r_len <= s_wdata_i[LEN_W-1:0];
                    default: ;
                endcase
            end

            if (w_cfg_wr && (s_addr_i == 2'd3)) begin
                r_irq_en <= s_wdata_i[4];
                if (s_wdata_i[2]) r_done <= 1'b0;
                if (s_wdata_i[3]) r_err  <= 1'b0;
            end

            if (w_start) begin
                r_cur_src   <= r_src;
                r_cur_dst   <= r_dst;
                r_remaining <= r_len;
                r_done      <= (r_len == '0);
                r_err       <= 1'b0;
            end

            if (w_abort) begin
                r_err  <= 1'b1;
                r_done <= 1'b0;
            end else if (w_chunk_end) begin
                r_cur_src   <= r_cur_src + WB_AW'(w_chunk);
                r_cur_dst   <= r_cur_dst + WB_AW'(w_chunk);
                r_remaining <= r_remaining - LEN_W'(w_chunk);
                if (w_final) r_done <= 1'b1;
            end

            if (!w_active || w_abort) begin
                r_issued      <= '0;
                r_acked       <= '0;
                r_outstanding <= '0;
            end else begin
                r_issued      <= r_issued + CW'(w_accept);
                r_acked       <= r_acked + CW'(w_ack);
                r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_ack);
            end

            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if ((r_state == S_RD) && w_ack)    r_wr_ptr <= r_wr_ptr + PW'(1);
                if ((r_state == S_WR) && w_accept) r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if ((r_state == S_RD) && w_ack && !w_abort) r_mem[r_wr_ptr] <= m_rdata_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dma_copy
// Function : Directed bench for wb_dma_copy with a pipelined memory responder.
// Revision : 1.0
// ============================================================================
module tb_wb_dma_copy;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [1:0]  s_addr_i = '0;
    logic [31:0] s_wdata_i = '0;
    logic [3:0]  s_sel_i = 4'hF;
    logic        s_stall_o, s_ack_o, s_err_o;
    logic [31:0] s_rdata_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [3:0]  m_sel_o;
    logic        m_stall_i = 1'b0, m_ack_i = 1'b0, m_err_i = 1'b0;
    logic [31:0] m_rdata_i = '0;
    logic        irq_o;

    wb_dma_copy dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i),
        .s_wdata_i(s_wdata_i), .s_sel_i(s_sel_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
        .s_err_o(s_err_o), .s_rdata_o(s_rdata_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o), .m_sel_o(m_sel_o), .m_stall_i(m_stall_i), .m_ack_i(m_ack_i),
        .m_err_i(m_err_i), .m_rdata_i(m_rdata_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder / bus monitor ----------------
    typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int due;} req_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int cyc;} log_t;

    logic [31:0] mem [1024];
    req_t pend[$];
    log_t acc_log[$];
    int   bursts[$];
    int   cyc_n = 0, stall_pct = 0, lat_min = 0, lat_max = 0;
    int   wr_acks = 0, err_at = 0, burst_cnt = 0, cyc_cycles = 0;
    int   hold_err = 0, gap_err = 0;
    logic err_chk = 1'b0, err_fired = 1'b0, cyc_after_err = 1'b1;
    logic prev_stalled = 1'b0, prev_cyc = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    req_t r;

    always @(negedge clk) begin
        cyc_n++;
        if (err_chk) begin
            cyc_after_err = m_cyc_o | m_stb_o;
            err_chk = 1'b0;
        end
        if (prev_stalled &&
            !(m_stb_o && m_addr_o == prev_addr && m_we_o == prev_we && (!m_we_o || m_wdata_o == prev_wdata)))
            hold_err++;
        if (m_cyc_o && prev_cyc && m_we_o != prev_we) gap_err++;

        m_stall_i = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;
        if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            r = pend.pop_front();
            if (r.we) begin
                wr_acks++;
                if (wr_acks == err_at) begin
                    m_err_i = 1'b1; err_chk = 1'b1; err_fired = 1'b1;
                    pend.delete();
                end else m_ack_i = 1'b1;
            end else begin
                m_ack_i = 1'b1;
                m_rdata_i = mem[r.addr[9:0]];
            end
        end

        if (m_cyc_o && m_stb_o && !m_stall_i) begin
            acc_log.push_back('{m_we_o, m_addr_o, m_we_o ? m_wdata_o : 32'h0, cyc_n});
            if (m_we_o) mem[m_addr_o[9:0]] = m_wdata_o;
            pend.push_back('{m_we_o, m_addr_o, m_wdata_o, cyc_n + 1 + $urandom_range(lat_max, lat_min)});
            burst_cnt++;
        end
        if (m_cyc_o) cyc_cycles++;
        if (prev_cyc && !m_cyc_o) begin
            bursts.push_back(burst_cnt);
            burst_cnt = 0;
        end
        prev_stalled = m_cyc_o && m_stb_o && m_stall_i;
        prev_addr = m_addr_o; prev_wdata = m_wdata_o;
        prev_cyc = m_cyc_o; prev_we = m_we_o;
    end

    // ---------------- config port tasks ----------------
    logic rd_ack;

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] d);
        @(negedge clk);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_addr_i = idx; s_wdata_i = d;
        @(negedge clk);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] idx, output logic [31:0] d);
        @(negedge clk);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_addr_i = idx;
        @(negedge clk);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        d = s_rdata_o; rd_ack = s_ack_o;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] d;
        int n = 0;
        do begin
            cfg_read(2'd3, d);
            n++;
        end while (d[1] && n < 3000);
        check(name, {63'b0, d[1]}, 64'd0);
    endtask

    task automatic clear_mon();
        acc_log.delete(); bursts.delete();
        burst_cnt = 0; cyc_cycles = 0; wr_acks = 0;
    endtask

    typedef struct {logic we; logic [1:0] idx; logic [31:0] data; logic [31:0] exp;} vec_t;
    vec_t vecs[11];

    initial begin
        logic [31:0] d;
        int n;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst m_cyc", {63'b0, m_cyc_o}, 64'd0);
        check("rst m_sel", {60'b0, m_sel_o}, 64'hF);
        check("rst irq", {63'b0, irq_o}, 64'd0);

        // -------- register access table --------
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 2'd0, 32'hABCD1234, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,        32'hABCD1234};
        vecs[5]  = '{1'b1, 2'd1, 32'h00000055, 32'h0};
        vecs[6]  = '{1'b0, 2'd1, 32'h0,        32'h00000055};
        vecs[7]  = '{1'b1, 2'd2, 32'h000F0012, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 32'h0,        32'h00000012};
        vecs[9]  = '{1'b1, 2'd3, 32'h00000010, 32'h0};
        vecs[10] = '{1'b0, 2'd3, 32'h0,        32'h00000010};
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) cfg_write(vecs[i].idx, vecs[i].data);
            else begin
                cfg_read(vecs[i].idx, d);
                check($sformatf("reg vec %0d", i), {32'b0, d}, {32'b0, vecs[i].exp});
                check($sformatf("reg ack %0d", i), {63'b0, rd_ack}, 64'd1);
            end
        end
        cfg_write(2'd3, 32'h0);

        // -------- A: basic copy, no stalls --------
        mem[10'h100] = 32'h1111_AAAA; mem[10'h101] = 32'h2222_BBBB; mem[10'h102] = 32'h3333_CCCC;
        clear_mon();
        stall_pct = 0; lat_min = 0; lat_max = 0;
        cfg_write(2'd0, 32'h100); cfg_write(2'd1, 32'h200); cfg_write(2'd2, 32'd3);
        cfg_write(2'd3, 32'h1);
        wait_idle("A timeout");
        check("A count", 64'(acc_log.size()), 64'd6);
        if (acc_log.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
                check("A rd", {acc_log[k].we, acc_log[k].addr}, {1'b0, 32'h100 + 32'(k)});
                check("A wr", {acc_log[3+k].we, acc_log[3+k].addr, acc_log[3+k].data},
                      {1'b1, 32'h200 + 32'(k), mem[10'h100 + 10'(k)]});
            end
            check("A b2b", 64'(acc_log[2].cyc - acc_log[0].cyc), 64'd2);
        end
        check("A bursts", 64'(bursts.size()), 64'd2);
        cfg_read(2'd3, d);
        check("A ctrl", {32'b0, d}, 64'h4);

        // -------- B: multi-chunk, random stalls and latency --------
        for (int k = 0; k < 20; k++) begin
            mem[10'h300 + 10'(k)] = 32'hB000_0000 + 32'(k) * 32'h0001_1111;
            mem[10'h3A0 + 10'(k)] = 32'h0;
        end
        clear_mon();
        stall_pct = 40; lat_min = 0; lat_max = 5;
        cfg_write(2'd0, 32'h300); cfg_write(2'd1, 32'h3A0); cfg_write(2'd2, 32'd20);
        cfg_write(2'd3, 32'h1);
        wait_idle("B timeout");
        for (int k = 0; k < 20; k++)
            check($sformatf("B word %0d", k), {32'b0, mem[10'h3A0 + 10'(k)]},
                  {32'b0, 32'hB000_0000 + 32'(k) * 32'h0001_1111});
        check("B nbursts", 64'(bursts.size()), 64'd6);
        if (bursts.size() == 6) begin
            check("B chunk0", 64'(bursts[0]), 64'd8);
            check("B chunk2", 64'(bursts[2]), 64'd8);
            check("B chunk4", 64'(bursts[4]), 64'd4);
            check("B chunk5", 64'(bursts[5]), 64'd4);
        end
        check("B stall hold", 64'(hold_err), 64'd0);

        // -------- C: busy protection --------
        clear_mon();
        stall_pct = 50; lat_min = 2; lat_max = 5;
        cfg_write(2'd0, 32'h040); cfg_write(2'd1, 32'h080); cfg_write(2'd2, 32'd10);
        cfg_write(2'd3, 32'h1);
        cfg_read(2'd3, d);
        check("C busy", {32'b0, d}, 64'h2);
        cfg_write(2'd2, 32'd99);
        cfg_write(2'd3, 32'h1);
        wait_idle("C timeout");
        n = 0;
        foreach (acc_log[i]) if (acc_log[i].we) n++;
        check("C writes", 64'(n), 64'd10);
        cfg_read(2'd2, d);
        check("C len", {32'b0, d}, 64'd10);

        // -------- D: LEN=0 --------
        stall_pct = 0; lat_min = 0; lat_max = 0;
        cfg_write(2'd2, 32'd0);
        clear_mon();
        cfg_write(2'd3, 32'h11);
        cfg_read(2'd3, d);
        check("D ctrl", {32'b0, d}, 64'h14);
        check("D irq", {63'b0, irq_o}, 64'd1);
        check("D no cyc", 64'(cyc_cycles), 64'd0);

        // -------- E: error abort on 2nd write ack --------
        clear_mon();
        err_at = 2; err_fired = 1'b0; cyc_after_err = 1'b1;
        cfg_write(2'd0, 32'h100); cfg_write(2'd1, 32'h280); cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'h11);
        wait_idle("E timeout");
        check("E err fired", {63'b0, err_fired}, 64'd1);
        check("E cyc after err", {63'b0, cyc_after_err}, 64'd0);
        cfg_read(2'd3, d);
        check("E ctrl", {32'b0, d}, 64'h18);
        check("E irq", {63'b0, irq_o}, 64'd1);
        cfg_read(2'd2, d);
        check("E len kept", {32'b0, d}, 64'd4);
        cfg_write(2'd3, 32'h18);
        @(negedge clk);
        check("E irq cleared", {63'b0, irq_o}, 64'd0);
        cfg_read(2'd3, d);
        check("E ctrl w1c", {32'b0, d}, 64'h10);
        err_at = 0;

        // -------- F: reset mid-read --------
        clear_mon();
        lat_min = 5; lat_max = 5;
        cfg_write(2'd2, 32'd8);
        cfg_write(2'd3, 32'h1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (pend.size() < 3 && n < 50);
        check("F outstanding", 64'(pend.size() >= 3), 64'd1);
        rst_i = 1'b1;
        @(negedge clk); #1;
        rst_i = 1'b0;
        check("F rst bus", {59'b0, m_cyc_o, m_stb_o, m_we_o, irq_o, s_ack_o}, 64'd0);
        check("F rst addr", {32'b0, m_addr_o}, 64'd0);
        check("F rst sel", {60'b0, m_sel_o}, 64'hF);
        cyc_cycles = 0;
        repeat (12) @(negedge clk);
        check("F stray acks", 64'(cyc_cycles), 64'd0);
        cfg_read(2'd3, d);
        check("F ctrl", {32'b0, d}, 64'h0);
        cfg_read(2'd0, d);
        check("F src", {32'b0, d}, 64'h0);

        check("gap between phases", 64'(gap_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Word-granular memory-to-memory copy engine and the second bus initiator on the platform crossbar.
- Configured through a Wishbone pipelined responder port that sits as a crossbar slave.
- Moves data through its own Wishbone pipelined initiator port, which attaches as crossbar master 1 next to the core LSU.
- Copies LEN words from SRC to DST in chunks of up to MAX_BURST words, buffered in an internal FIFO: read chunk, then write chunk.

Parameters:
- WB_AW, 32, Wishbone word-address width, both ports.
- WB_DW, 32, Wishbone data width, both ports.
- MAX_BURST, 8, words per chunk and FIFO depth; power of two, 2..64.
- LEN_W, 16, width of the LEN register, in words.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- s_cyc_i / s_stb_i / s_we_i, input, 1 each, config responder control.
- s_addr_i, input, 2, config register word index.
- s_wdata_i, input, WB_DW, config write data.
- s_sel_i, input, WB_DW/8, byte selects; ignored, writes are full-word.
- s_stall_o / s_ack_o / s_err_o, output, 1 each, config responder response.
- s_rdata_o, output, WB_DW, config read data.
- m_cyc_o / m_stb_o / m_we_o, output, 1 each, DMA initiator control.
- m_addr_o, output, WB_AW, DMA word address.
- m_wdata_o, output, WB_DW, DMA write data.
- m_sel_o, output, WB_DW/8, DMA byte selects; always all-ones.
- m_stall_i / m_ack_i / m_err_i, input, 1 each, DMA initiator response.
- m_rdata_i, input, WB_DW, DMA read data.
- irq_o, output, 1, level interrupt.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (rst_i). All state changes occur on the rising clk_i edge.
- Reset values:
  - All outputs 0, except m_sel_o, which is all-ones.
  - Registers SRC=0, DST=0, LEN=0, CTRL=0. FIFO empty. State IDLE.
- Config port:
  - s_stall_o is tied 0 and s_err_o is tied 0.
  - s_ack_o pulses exactly one cycle after each cycle in which s_cyc_i&s_stb_i.
  - s_rdata_o is valid with the ack and is 0 otherwise.
- Register map:
  - Index 0 SRC: word address.
  - Index 1 DST: word address.
  - Index 2 LEN: LEN_W bits, zero-extended on read.
  - Index 3 CTRL: bit0 START (write-1, reads 0); bit1 BUSY (RO); bit2 DONE (sticky, W1C); bit3 ERR (sticky, W1C); bit4 IRQ_EN (RW).
- Writes while busy:
  - Writes to SRC, DST and LEN while BUSY=1 are ignored.
  - START while BUSY=1 is ignored.
  - IRQ_EN and the W1C bits remain writable while BUSY=1.
- START accepted:
  - Internal copies are latched: cur_src=SRC, cur_dst=DST, remaining=LEN.
  - DONE and ERR are cleared in the same write; a W1C in the same write is then irrelevant.
  - BUSY=1 from the next cycle.
  - If LEN=0: no bus activity; DONE=1 and BUSY=0 one cycle later.
- State IDLE: waits for START.
- State RD:
  - chunk = min(remaining, MAX_BURST).
  - m_cyc_o=1 and m_we_o=0. m_stb_o is asserted with m_addr_o=cur_src+k, for k=0..chunk-1.
  - A request is accepted on a cycle with m_stb_o&!m_stall_i; stb and addr are held stable while stalled.
  - Requests are pipelined back-to-back; no wait for acks between them.
  - Each m_ack_i pushes m_rdata_i into the FIFO, in order.
  - After chunk requests are issued, m_stb_o=0.
  - When acks == chunk: m_cyc_o deasserts for at least one cycle, then the state moves to WR.
- State WR:
  - Same rules as RD, with m_we_o=1, m_addr_o=cur_dst+k, and m_wdata_o=FIFO head.
  - The FIFO pops on each accepted request.
  - When acks == chunk:
    - cur_src += chunk, cur_dst += chunk, remaining -= chunk.
    - If remaining=0: DONE=1, BUSY=0, state IDLE.
    - Otherwise: state RD.
  - m_cyc_o drops between chunks.
- Outstanding counter:
  - Width is clog2(MAX_BURST)+1.
  - Increments on an accepted request and decrements on an ack.
  - An accept and an ack in the same cycle leave it unchanged.
  - Acks arriving with zero outstanding are ignored.
- Error handling:
  - m_err_i while m_cyc_o=1 aborts the transfer.
  - m_cyc_o and m_stb_o are 0 the next cycle; the FIFO is flushed.
  - ERR=1, DONE=0, BUSY=0, state IDLE.
  - Registers SRC, DST and LEN are unchanged.
- Address arithmetic: modulo 2^WB_AW; wrap-around is allowed and not flagged.
- irq_o = IRQ_EN & (DONE | ERR). It is level-sensitive and is cleared by W1C or by a new START.
- Reset mid-transfer: m_cyc_o and m_stb_o are 0 in the cycle after the reset edge. All state returns to reset values, and late acks are ignored.

Test Plan:
- Basic copy, no stalls: SRC=0x100, DST=0x200, LEN=3, START. Expect 3 back-to-back reads at 0x100..0x102, cyc low ≥1 cycle, then 3 writes to 0x200..0x202 with the read data in order, then DONE=1 and BUSY=0.
- Multi-chunk with stalls: LEN=20, MAX_BURST=8, random m_stall_i and ack latency 0..5. Expect chunks of 8, 8 and 4, stb/addr held stable during stalls, and the destination matching the source word-for-word.
- Busy protection: while BUSY, write LEN=99 and START. Expect the transfer to finish at the original LEN and a LEN readback equal to the original value.
- LEN=0: write START. Expect zero m_cyc_o cycles, DONE=1 after 1 cycle, and irq_o=1 when IRQ_EN=1.
- Error abort: m_err_i on the 2nd write ack of LEN=4. Expect cyc=0 next cycle, ERR=1, irq_o=1 with IRQ_EN set, and W1C of bit3 clearing irq_o.
- Reset mid-RD: assert rst_i with 3 reads outstanding. Expect outputs at reset values next cycle, CTRL=0, and subsequent stray acks ignored.
